// File: rtl/lsu_mem_initiator.sv
// rtl/lsu_mem_initiator.sv - single-outstanding LSU request engine for the core's simple memory port
// Splits a load/store into a word-aligned lane-masked access, waits LATENCY cycles, returns the response.
module lsu_mem_initiator #(
  parameter int LATENCY = 0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_ren,
  output logic [31:0] mem_raddr,
  input  logic [31:0] mem_rdata,
  output logic        mem_wen,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [3:0] LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wen_q, wen_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  logic        req_bad;
  logic [31:0] rd_shift;
  logic [31:0] rd_ext;
  logic [3:0]  mask_base;
  logic [3:0]  mask_sh;
  logic [31:0] wdata_sh;
  logic [31:0] word_addr;

  assign req_bad = (req_size == 2'd3) ||
                   ((req_size == 2'd1) && req_addr[0]) ||
                   ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));

  assign word_addr = {addr_q[31:2], 2'b00};
  assign rd_shift  = mem_rdata >> {addr_q[1:0], 3'b000};
  assign wdata_sh  = wdata_q << {addr_q[1:0], 3'b000};
  assign mask_sh   = mask_base << addr_q[1:0];

  always_comb begin
    mask_base = 4'b1111;
    rd_ext    = rd_shift;
    case (size_q)
      2'd0: begin
        mask_base = 4'b0001;
        rd_ext    = uns_q ? {24'd0, rd_shift[7:0]} : {{24{rd_shift[7]}}, rd_shift[7:0]};
      end
      2'd1: begin
        mask_base = 4'b0011;
        rd_ext    = uns_q ? {16'd0, rd_shift[15:0]} : {{16{rd_shift[15]}}, rd_shift[15:0]};
      end
      default: begin
        mask_base = 4'b1111;
        rd_ext    = rd_shift;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wen_d   = wen_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    uns_d   = uns_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          wen_d   = req_wen;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          size_d  = req_size;
          uns_d   = req_unsigned;
          err_d   = req_bad;
          rdata_d = 32'd0;
          state_d = req_bad ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        if (LATENCY == 0) begin
          if (!wen_q) rdata_d = rd_ext;
          state_d = RESP;
        end else begin
          cnt_d   = LAT_M1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // Read data is sampled only on the edge leaving the final wait cycle.
        if (cnt_q == 4'd0) begin
          if (!wen_q) rdata_d = rd_ext;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          rdata_d = 32'd0;
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      wen_q   <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      size_q  <= 2'd0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Port outputs are gated by state so they read as zero whenever no access is in flight.
  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = (state_q == RESP) ? rdata_q : 32'd0;
  assign resp_err   = (state_q == RESP) ? err_q : 1'b0;

  assign mem_ren   = !wen_q && ((state_q == ISSUE) || (state_q == WAIT));
  assign mem_raddr = mem_ren ? word_addr : 32'd0;
  assign mem_wen   = wen_q && (state_q == ISSUE);
  assign mem_waddr = mem_wen ? word_addr : 32'd0;
  assign mem_wdata = mem_wen ? wdata_sh : 32'd0;
  assign mem_wmask = mem_wen ? mask_sh : 4'd0;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// tb/tb_lsu_mem_initiator.sv - directed bench for lsu_mem_initiator at LATENCY 0 and 3
module tb_lsu_mem_initiator;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset_n;
  logic [1:0]       rv, rwen, runs, rr;
  logic [1:0][31:0] raddr_in, rwdata;
  logic [1:0][1:0]  rsize;
  logic [1:0]       rrdy, resp_v, resp_e, mren, mwen;
  logic [1:0][31:0] resp_d, mraddr, mrdata, mwaddr, mwdata;
  logic [1:0][3:0]  mwmask;

  logic [31:0] mem0 [16];
  logic [31:0] mem1 [16];

  int n_cmp = 0;
  int n_bad = 0;

  lsu_mem_initiator #(.LATENCY(0)) dut0 (
    .clock(clock), .reset_n(reset_n),
    .req_valid(rv[0]), .req_ready(rrdy[0]), .req_wen(rwen[0]), .req_addr(raddr_in[0]),
    .req_wdata(rwdata[0]), .req_size(rsize[0]), .req_unsigned(runs[0]),
    .resp_valid(resp_v[0]), .resp_ready(rr[0]), .resp_rdata(resp_d[0]), .resp_err(resp_e[0]),
    .mem_ren(mren[0]), .mem_raddr(mraddr[0]), .mem_rdata(mrdata[0]),
    .mem_wen(mwen[0]), .mem_waddr(mwaddr[0]), .mem_wdata(mwdata[0]), .mem_wmask(mwmask[0])
  );

  lsu_mem_initiator #(.LATENCY(3)) dut1 (
    .clock(clock), .reset_n(reset_n),
    .req_valid(rv[1]), .req_ready(rrdy[1]), .req_wen(rwen[1]), .req_addr(raddr_in[1]),
    .req_wdata(rwdata[1]), .req_size(rsize[1]), .req_unsigned(runs[1]),
    .resp_valid(resp_v[1]), .resp_ready(rr[1]), .resp_rdata(resp_d[1]), .resp_err(resp_e[1]),
    .mem_ren(mren[1]), .mem_raddr(mraddr[1]), .mem_rdata(mrdata[1]),
    .mem_wen(mwen[1]), .mem_waddr(mwaddr[1]), .mem_wdata(mwdata[1]), .mem_wmask(mwmask[1])
  );

  assign mrdata[0] = mem0[mraddr[0][5:2]];
  assign mrdata[1] = mem1[mraddr[1][5:2]];

  always @(posedge clock) begin
    for (int b = 0; b < 4; b++) begin
      if (mwen[0] && mwmask[0][b]) mem0[mwaddr[0][5:2]][b*8 +: 8] <= mwdata[0][b*8 +: 8];
      if (mwen[1] && mwmask[1][b]) mem1[mwaddr[1][5:2]][b*8 +: 8] <= mwdata[1][b*8 +: 8];
    end
  end

  // Drives one request from a negedge, observes each later negedge until resp_valid, then handshakes.
  task automatic run_req(input int s, input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] sz, input logic u, input int hold,
                         output int lat, output int wcnt, output int rcnt,
                         output logic [31:0] wa, output logic [31:0] wd, output logic [3:0] wm,
                         output logic rstable, output logic [31:0] rd, output logic er,
                         output logic hold_ok, output logic idle_ok);
    logic [31:0] ra0;
    lat = -1; wcnt = 0; rcnt = 0; wa = 0; wd = 0; wm = 0; rstable = 1'b1;
    rd = 0; er = 0; hold_ok = 1'b1; idle_ok = 1'b0; ra0 = 0;
    rv[s] = 1'b1; rwen[s] = w; raddr_in[s] = a; rwdata[s] = d; rsize[s] = sz; runs[s] = u;
    @(posedge clock);
    @(negedge clock);
    rv[s] = 1'b0; raddr_in[s] = 32'h0000_0fff; rwdata[s] = 32'hffff_ffff; rsize[s] = 2'd3;
    for (int k = 1; k <= 40; k++) begin
      if (mwen[s]) begin wcnt++; wa = mwaddr[s]; wd = mwdata[s]; wm = mwmask[s]; end
      if (mren[s]) begin
        if (rcnt == 0) ra0 = mraddr[s];
        else if (mraddr[s] !== ra0) rstable = 1'b0;
        rcnt++;
      end
      if (resp_v[s]) begin lat = k; break; end
      @(negedge clock);
    end
    if (lat < 0) return;
    rd = resp_d[s];
    er = resp_e[s];
    repeat (hold) begin
      @(negedge clock);
      if (!resp_v[s] || resp_d[s] !== rd || resp_e[s] !== er || rrdy[s] !== 1'b0) hold_ok = 1'b0;
    end
    rr[s] = 1'b1;
    @(posedge clock);
    @(negedge clock);
    rr[s] = 1'b0;
    idle_ok = (rrdy[s] === 1'b1) && (resp_v[s] === 1'b0) && (resp_d[s] === 32'd0) && (resp_e[s] === 1'b0);
  endtask

  int lat, wcnt, rcnt;
  logic [31:0] wa, wd, rd;
  logic [3:0] wm;
  logic rst_ok, er, hold_ok, idle_ok;

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    for (int s = 0; s < 2; s++) begin
      n_cmp++;
      if (rrdy[s] !== 1'b1 || resp_v[s] !== 1'b0 || resp_e[s] !== 1'b0 || resp_d[s] !== 32'd0) begin
        n_bad++;
        $display("FAIL reset_resp dut%0d: ready=%b valid=%b err=%b rdata=%h, required 1 0 0 0", s, rrdy[s], resp_v[s], resp_e[s], resp_d[s]);
      end
      n_cmp++;
      if (mren[s] !== 1'b0 || mwen[s] !== 1'b0 || mraddr[s] !== 32'd0 || mwaddr[s] !== 32'd0 ||
          mwdata[s] !== 32'd0 || mwmask[s] !== 4'd0) begin
        n_bad++;
        $display("FAIL reset_mem dut%0d: ren=%b wen=%b raddr=%h waddr=%h wdata=%h wmask=%b, required all 0", s, mren[s], mwen[s], mraddr[s], mwaddr[s], mwdata[s], mwmask[s]);
      end
    end
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_store_word();
    run_req(0, 1'b1, 32'h8000_0004, 32'hDEAD_BEEF, 2'd2, 1'b0, 0, lat, wcnt, rcnt, wa, wd, wm, rst_ok, rd, er, hold_ok, idle_ok);
    n_cmp++;
    if (lat !== 2 || wcnt !== 1 || rcnt !== 0 || er !== 1'b0 || rd !== 32'd0) begin
      n_bad++;
      $display("FAIL store_word_timing: lat=%0d wen_cycles=%0d ren_cycles=%0d err=%b rdata=%h, required 2 1 0 0 0", lat, wcnt, rcnt, er, rd);
    end
    n_cmp++;
    if (wa !== 32'h8000_0004 || wm !== 4'b1111 || wd !== 32'hDEAD_BEEF) begin
      n_bad++;
      $display("FAIL store_word_port: waddr=%h wmask=%b wdata=%h, required 80000004 1111 deadbeef", wa, wm, wd);
    end
    n_cmp++;
    if (idle_ok !== 1'b1 || mem0[1] !== 32'hDEAD_BEEF) begin
      n_bad++;
      $display("FAIL store_word_commit: idle_clear=%b mem=%h, required 1 deadbeef", idle_ok, mem0[1]);
    end
  endtask

  task automatic test_store_lanes();
    run_req(0, 1'b1, 32'h8000_0000, 32'h1122_3344, 2'd2, 1'b0, 0, lat, wcnt, rcnt, wa, wd, wm, rst_ok, rd, er, hold_ok, idle_ok);
    run_req(0, 1'b1, 32'h8000_0003, 32'h0000_00A5, 2'd0, 1'b0, 0, lat, wcnt, rcnt, wa, wd, wm, rst_ok, rd, er, hold_ok, idle_ok);
    n_cmp++;
    if (wa !== 32'h8000_0000 || wm !== 4'b1000 || wd !== 32'hA500_0000 || wcnt !== 1 || lat !== 2) begin
      n_bad++;
      $display("FAIL store_byte: waddr=%h wmask=%b wdata=%h wen_cycles=%0d lat=%0d, required 80000000 1000 a5000000 1 2", wa, wm, wd, wcnt, lat);
    end
    n_cmp++;
    if (mem0[0] !== 32'hA522_3344) begin
      n_bad++;
      $display("FAIL store_byte_merge: mem=%h, required a5223344", mem0[0]);
    end
    run_req(0, 1'b1, 32'h8000_0002, 32'hFFFF_1234, 2'd1, 1'b0, 0, lat, wcnt, rcnt, wa, wd, wm, rst_ok, rd, er, hold_ok, idle_ok);
    n_cmp++;
    if (wm !== 4'b1100 || wd !== 32'h1234_0000 || mem0[0] !== 32'h1234_3344) begin
      n_bad++;
      $display("FAIL store_half_hi: wmask=%b wdata=%h mem=%h, required 1100 12340000 12343344", wm, wd, mem0[0]);
    end
  endtask

  task automatic test_load_extend();
    logic [31:0] la [5];
    logic [1:0]  ls [5];
    logic        lu [5];
    logic [31:0] le [5];
    la = '{32'h8000_0002, 32'h8000_0000, 32'h8000_0001, 32'h8000_0000, 32'h8000_0000};
    ls = '{2'd1, 2'd0, 2'd0, 2'd1, 2'd2};
    lu = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    le = '{32'hFFFF_8001, 32'h0000_007F, 32'hFFFF_FFF0, 32'h0000_F07F, 32'h8001_F07F};
    run_req(0, 1'b1, 32'h8000_0000, 32'h8001_F07F, 2'd2, 1'b0, 0, lat, wcnt, rcnt, wa, wd, wm, rst_ok, rd, er, hold_ok, idle_ok);
    for (int i = 0; i < 5; i++) begin
      run_req(0, 1'b0, la[i], 32'h0, ls[i], lu[i], 0, lat, wcnt, rcnt, wa, wd, wm, rst_ok, rd, er, hold_ok, idle_ok);
      n_cmp++;
      if (rd !== le[i] || er !== 1'b0 || lat !== 2 || rcnt !== 1 || wcnt !== 0 || idle_ok !== 1'b1) begin
        n_bad++;
        $display("FAIL load_extend[%0d]: rdata=%h err=%b lat=%0d ren_cycles=%0d wen_cycles=%0d idle_clear=%b, required %h 0 2 1 0 1", i, rd, er, lat, rcnt, wcnt, idle_ok, le[i]);
      end
    end
  endtask

  task automatic test_latency3();
    run_req(1, 1'b1, 32'h8000_0008, 32'hCAFE_F00D, 2'd2, 1'b0, 0, lat, wcnt, rcnt, wa, wd, wm, rst_ok, rd, er, hold_ok, idle_ok);
    n_cmp++;
    if (lat !== 5 || wcnt !== 1 || mem1[2] !== 32'hCAFE_F00D) begin
      n_bad++;
      $display("FAIL lat3_store: lat=%0d wen_cycles=%0d mem=%h, required 5 1 cafef00d", lat, wcnt, mem1[2]);
    end
    run_req(1, 1'b0, 32'h8000_0008, 32'h0, 2'd2, 1'b0, 3, lat, wcnt, rcnt, wa, wd, wm, rst_ok, rd, er, hold_ok, idle_ok);
    n_cmp++;
    if (lat !== 5 || rcnt !== 4 || rst_ok !== 1'b1) begin
      n_bad++;
      $display("FAIL lat3_load_timing: lat=%0d ren_cycles=%0d raddr_stable=%b, required 5 4 1", lat, rcnt, rst_ok);
    end
    n_cmp++;
    if (rd !== 32'hCAFE_F00D || hold_ok !== 1'b1 || idle_ok !== 1'b1) begin
      n_bad++;
      $display("FAIL lat3_load_hold: rdata=%h held_stable=%b idle_clear=%b, required cafef00d 1 1", rd, hold_ok, idle_ok);
    end
    run_req(1, 1'b0, 32'h8000_000A, 32'h0, 2'd0, 1'b0, 0, lat, wcnt, rcnt, wa, wd, wm, rst_ok, rd, er, hold_ok, idle_ok);
    n_cmp++;
    if (rd !== 32'hFFFF_FFFE || lat !== 5) begin
      n_bad++;
      $display("FAIL lat3_byte_signed: rdata=%h lat=%0d, required fffffffe 5", rd, lat);
    end
  endtask

  task automatic test_errors();
    int          es [5];
    logic        ew [5];
    logic [31:0] ea [5];
    logic [1:0]  ez [5];
    es = '{0, 0, 0, 0, 1};
    ew = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    ea = '{32'h8000_0002, 32'h8000_0000, 32'h8000_0001, 32'h8000_0001, 32'h8000_0006};
    ez = '{2'd2, 2'd3, 2'd1, 2'd2, 2'd2};
    for (int i = 0; i < 5; i++) begin
      run_req(es[i], ew[i], ea[i], 32'hFFFF_FFFF, ez[i], 1'b0, 0, lat, wcnt, rcnt, wa, wd, wm, rst_ok, rd, er, hold_ok, idle_ok);
      n_cmp++;
      if (lat !== 1 || er !== 1'b1 || rd !== 32'd0 || wcnt !== 0 || rcnt !== 0 || idle_ok !== 1'b1) begin
        n_bad++;
        $display("FAIL error[%0d]: lat=%0d err=%b rdata=%h wen_cycles=%0d ren_cycles=%0d idle_clear=%b, required 1 1 0 0 0 1", i, lat, er, rd, wcnt, rcnt, idle_ok);
      end
    end
    n_cmp++;
    if (mem0[0] !== 32'h8001_F07F) begin
      n_bad++;
      $display("FAIL error_no_write: mem=%h, required 8001f07f", mem0[0]);
    end
  endtask

  task automatic test_back_to_back();
    run_req(0, 1'b1, 32'h8000_000C, 32'h0BAD_F00D, 2'd2, 1'b0, 0, lat, wcnt, rcnt, wa, wd, wm, rst_ok, rd, er, hold_ok, idle_ok);
    run_req(0, 1'b0, 32'h8000_000E, 32'h0, 2'd1, 1'b1, 0, lat, wcnt, rcnt, wa, wd, wm, rst_ok, rd, er, hold_ok, idle_ok);
    n_cmp++;
    if (rd !== 32'h0000_0BAD || lat !== 2) begin
      n_bad++;
      $display("FAIL back_to_back: rdata=%h lat=%0d, required 00000bad 2", rd, lat);
    end
  endtask

  task automatic test_reset_mid();
    logic seen;
    rv[1] = 1'b1; rwen[1] = 1'b0; raddr_in[1] = 32'h8000_0008; rsize[1] = 2'd2; runs[1] = 1'b0;
    @(posedge clock);
    @(negedge clock);
    rv[1] = 1'b0;
    @(negedge clock);
    n_cmp++;
    if (mren[1] !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_load_pre: ren=%b, required 1", mren[1]);
    end
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (mren[1] !== 1'b0 || mraddr[1] !== 32'd0 || resp_v[1] !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_load_drop: ren=%b raddr=%h valid=%b, required 0 0 0", mren[1], mraddr[1], resp_v[1]);
    end
    @(negedge clock);
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin @(negedge clock); if (resp_v[1] !== 1'b0 || mren[1] !== 1'b0) seen = 1'b1; end
    n_cmp++;
    if (seen !== 1'b0 || rrdy[1] !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_load_after: stray_activity=%b ready=%b, required 0 1", seen, rrdy[1]);
    end

    rv[0] = 1'b1; rwen[0] = 1'b1; raddr_in[0] = 32'h8000_0000; rwdata[0] = 32'h5555_5555; rsize[0] = 2'd2; runs[0] = 1'b0;
    @(posedge clock);
    @(negedge clock);
    rv[0] = 1'b0;
    n_cmp++;
    if (mwen[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_store_pre: wen=%b, required 1", mwen[0]);
    end
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (mwen[0] !== 1'b0 || mwmask[0] !== 4'd0) begin
      n_bad++;
      $display("FAIL mid_store_drop: wen=%b wmask=%b, required 0 0000", mwen[0], mwmask[0]);
    end
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (4) begin @(negedge clock); if (resp_v[0] !== 1'b0 || mwen[0] !== 1'b0) seen = 1'b1; end
    n_cmp++;
    if (seen !== 1'b0 || rrdy[0] !== 1'b1 || mem0[0] !== 32'h8001_F07F) begin
      n_bad++;
      $display("FAIL mid_store_after: stray_activity=%b ready=%b mem=%h, required 0 1 8001f07f", seen, rrdy[0], mem0[0]);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    rv = '0; rwen = '0; runs = '0; rr = '0;
    raddr_in = '0; rwdata = '0; rsize = '0;
    test_reset();
    test_store_word();
    test_store_lanes();
    test_load_extend();
    test_latency3();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lsu_mem_initiator.md
Name: lsu_mem_initiator

Overview:
- Requester-side engine for the core's simple memory port: `mem_ren`/`mem_raddr`/`mem_rdata` and `mem_wen`/`mem_waddr`/`mem_wdata`/`mem_wmask`, with combinational read data and a write committed at the clock edge.
- Accepts one load/store from the LSU over a valid/ready handshake.
- Converts the request into word-aligned port accesses with byte masks, waits a configurable number of cycles, then returns extracted and extended load data or a store acknowledge.
- Non-pipelined: one outstanding request.

Parameters:
- LATENCY, 0, extra wait cycles between the issue cycle and the response; legal range 0..15.

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request valid
- req_ready  out  1  request ready; high only in IDLE
- req_wen  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
- resp_valid  out  1  response valid
- resp_ready  in  1  response accepted
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned or illegal-size request
- mem_ren  out  1  read enable
- mem_raddr  out  32  read word address
- mem_rdata  in  32  read data, combinational from mem_raddr
- mem_wen  out  1  write enable, sampled at posedge
- mem_waddr  out  32  write word address
- mem_wdata  out  32  lane-shifted write data
- mem_wmask  out  4  byte-lane mask

Behaviour:
- Reset (asynchronous, reset_n low): state goes to IDLE and the counter to 0.
  - resp_valid, resp_err, mem_ren, mem_wen = 0.
  - resp_rdata, all mem addresses/data, and mem_wmask = 0.
  - req_ready = 1.
- Reset mid-operation: the request is abandoned and strobes drop immediately. No response is produced and no write occurs at a later edge.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid & req_ready, register wen, addr, wdata, size and unsigned.
  - Error check: size 3, size 1 with addr[0] = 1, or size 2 with addr[1:0] != 0 is an error. An error goes straight to RESP with err = 1, rdata = 0, and no memory strobe. Otherwise go to ISSUE.
- Address: mem_raddr/mem_waddr = {addr[31:2], 2'b00}; lane off = addr[1:0].
- Store:
  - mem_wen = 1 for exactly the ISSUE cycle.
  - mem_wmask = (size 0: 4'b0001, size 1: 4'b0011, size 2: 4'b1111) << off.
  - mem_wdata = req_wdata << (8*off); bits shifted out are dropped.
- Load:
  - mem_ren = 1 from ISSUE through the last WAIT cycle.
  - mem_raddr is held stable throughout.
  - mem_rdata is captured at the rising edge that leaves the last access cycle: ISSUE if LATENCY = 0, otherwise the final WAIT.
  - Extract (mem_rdata >> 8*off)[7:0] or [15:0], or the full word.
  - Extend per req_unsigned.
- ISSUE:
  - LATENCY = 0: go to RESP.
  - Else load the counter with LATENCY-1 and go to WAIT.
- WAIT:
  - Counter decrements each cycle.
  - At 0, capture (loads) and go to RESP.
  - Exactly LATENCY WAIT cycles occur. mem_wen = 0 throughout WAIT.
- RESP:
  - resp_valid = 1; resp_rdata/resp_err stay stable until resp_ready.
  - On resp_valid & resp_ready go to IDLE; the response outputs clear to 0 in IDLE.
  - A new request is accepted no earlier than the cycle after the handshake.
- Timing: accept at cycle T gives ISSUE at T+1 and resp_valid at T+2+LATENCY. An error response is valid at T+1.
- All outputs except req_ready are registered or decoded from registered state. There is no combinational path from the req_* or resp_ready inputs to outputs.
- req_* inputs are ignored outside the IDLE accept cycle.

Test Plan:
1. LATENCY = 0, word store addr 0x80000004, data 0xDEADBEEF → mem_wen for one cycle; waddr 0x80000004, wmask 4'b1111, wdata 0xDEADBEEF; resp_valid at T+2, err 0.
2. Byte store addr 0x80000003, data 0x000000A5 → wmask 4'b1000, wdata 0xA5000000, waddr 0x80000000.
3. Memory word 0x80000000 = 0x8001F07F:
   - Signed half load at +2 → rdata 0xFFFF8001.
   - Unsigned byte load at +0 → rdata 0x0000007F.
   - Signed byte at +1 → rdata 0xFFFFFFF0.
4. LATENCY = 3, word load → mem_ren high 4 cycles with stable raddr; resp_valid at T+5.
   - Hold resp_ready low 3 cycles → rdata stable, req_ready low.
5. Misaligned word load addr 0x80000002, and size 3 → no mem_ren/mem_wen, resp_valid at T+1, resp_err 1, rdata 0.
6. Assert reset_n low during WAIT of a load and during ISSUE of a store → strobes drop asynchronously, no write committed, no resp_valid, req_ready 1 after release.
